binary_to_bcd_converter: RTL and testbench
==========================================

// Module: binary_to_bcd_converter
// PURPOSE
//  Sequential double-dabble converter: binary count -> packed BCD digits, one digit per nibble.
//  Sits between the up/down display counter and the Binary_To_7Segment decoders.
//  Each nibble of o_BCD drives one decoder, so the displays show decimal instead of hex.
//  Start/done handshake; one conversion in flight at a time.
// PARAMETERS
//  WIDTH   8  bit width of i_Binary
//  DIGITS  3  number of BCD digits produced (o_BCD width = 4*DIGITS)
// PORTS
//  i_Clk         in   1          system clock, all logic on rising edge
//  i_Rst_L       in   1          asynchronous active-low reset
//  i_Start       in   1          request conversion; sampled only in IDLE
//  i_Binary      in   WIDTH      value to convert; captured on accepted i_Start
//  o_Busy        out  1          conversion in progress
//  o_Done        out  1          1-cycle pulse: o_BCD/o_Overflow just updated
//  o_BCD         out  4*DIGITS   result; digit k in [4k+3:4k], digit 0 = units
//  o_Overflow    out  1          result exceeded 10^DIGITS-1 (registered with o_BCD)
//  o_Blank_Mask  out  DIGITS     bit k=1 -> digit k is a leading zero (see CONFIGURATION)
// BEHAVIOUR
//  Clock/reset: single clock i_Clk; reset i_Rst_L is asynchronous, active-low.
//  Reset values:
//   - o_Busy=0, o_Done=0, o_BCD=0, o_Overflow=0.
//   - o_Blank_Mask={DIGITS-1{1},0} with BCD_BLANK_EN; all zeros without it.
//   - FSM state=IDLE; internal scratch and iteration counter cleared.
//  FSM states:
//   - IDLE: i_Start=1 at edge N -> load scratch={DIGITS*4 zeros, i_Binary}, clear
//     iteration count and sticky overflow, o_Busy<=1, go to ADD3.
//   - ADD3: each BCD nibble >=5 gets +3 (all nibbles in parallel) -> SHIFT.
//   - SHIFT: scratch shifted left 1; bit leaving the top nibble ORs into sticky overflow;
//     count+1; if count==WIDTH -> DONE, else -> ADD3.
//   - DONE: o_BCD<=BCD field, o_Overflow<=sticky, o_Done<=1, o_Busy<=0 -> IDLE.
//  Latency: start accepted at edge N -> o_Done high for exactly the cycle after edge
//   N+2*WIDTH+1 (17 cycles for WIDTH=8).
//  o_Busy is high from edge N to edge N+2*WIDTH+1.
//  Back-to-back: i_Start during the o_Done cycle is accepted (FSM already IDLE);
//   throughput is one result per 2*WIDTH+2 cycles.
//  i_Start while o_Busy=1 (ADD3/SHIFT/DONE) is ignored; no queueing.
//  i_Binary is don't-care except in the accepting cycle; later changes do not affect the result.
//  o_BCD/o_Overflow/o_Blank_Mask hold the last result until the next DONE; never partial.
//  Overflow: o_BCD = value mod 10^DIGITS; o_Overflow=1 iff value >= 10^DIGITS.
//   Cannot occur for WIDTH=8, DIGITS=3.
//  Counter widths: iteration counter is $clog2(WIDTH+1) bits; no wrap before DONE.
//  Reset mid-conversion: aborts immediately, no o_Done; outputs take reset values.
// CONFIGURATION
//  BCD_BLANK_EN defined:
//   - o_Blank_Mask updated in the DONE cycle.
//   - Bit k=1 iff digit k and every higher digit are zero.
//   - Bit 0 always 0, so a value of 0 shows a single "0".
//  BCD_BLANK_EN undefined: o_Blank_Mask tied to all zeros; no blanking logic synthesised.
//  All other behaviour is identical in both configurations.
// TESTING (WIDTH=8, DIGITS=3 unless stated; BCD_BLANK_EN defined)
//  Start, i_Binary=0 -> o_Done exactly 17 cycles later; o_BCD=12'h000; o_Overflow=0;
//   o_Blank_Mask=3'b110.
//  Sweep i_Binary=0..255, each value started on its own o_Done cycle ->
//   o_BCD matches decimal (99->12'h099 with mask 3'b100; 255->12'h255 with mask 3'b000);
//   period 18 cycles.
//  Start 37, then pulse i_Start with i_Binary=200 at cycles 3 and 17 ->
//   single o_Done, o_BCD=12'h037; o_Busy high throughout.
//  Start 123, assert i_Rst_L=0 at cycle 8 for 2 cycles ->
//   outputs at reset values immediately; no o_Done; next start of 45 gives 12'h045.
//  DIGITS=2: start 99 -> o_BCD=8'h99, o_Overflow=0; start 150 -> o_BCD=8'h50, o_Overflow=1.
//  BCD_BLANK_EN undefined, start 5 -> o_BCD=12'h005; o_Blank_Mask=3'b000.

Source files
------------

// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble binary to packed-BCD converter.
// Optional leading-zero mask is built when BCD_BLANK_EN is defined.
module binary_to_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Start,
    input  logic [WIDTH-1:0]      i_Binary,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic [4*DIGITS-1:0]   o_BCD,
    output logic                  o_Overflow,
    output logic [DIGITS-1:0]     o_Blank_Mask
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD3,
        SHIFT,
        DONE
    } state_t;

    state_t         state;
    logic [SW-1:0]  scratch;
    logic [SW-1:0]  scratch_add3;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           ovf_sticky;

    assign count_next = count + 1'b1;

    // Correct every BCD nibble that would carry wrongly on the next shift
    always_comb begin
        scratch_add3 = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[WIDTH+4*k +: 4] >= 4'd5) begin
                scratch_add3[WIDTH+4*k +: 4] =
                    scratch[WIDTH+4*k +: 4] + 4'd3;
            end
        end
    end

`ifdef BCD_BLANK_EN
    localparam logic [DIGITS-1:0] MASK_RST = {DIGITS{1'b1}} << 1;

    logic [DIGITS-1:0] blank_next;
    logic              upper_zero;

    // Digit k blanks only when it and all digits above it are zero
    always_comb begin
        blank_next = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero    = upper_zero &&
                            (scratch[WIDTH+4*k +: 4] == 4'd0);
            blank_next[k] = upper_zero;
        end
    end

    // Mask is registered alongside the BCD result
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Blank_Mask <= MASK_RST;
        end else if (state == DONE) begin
            o_Blank_Mask <= blank_next;
        end
    end
`else
    assign o_Blank_Mask = '0;
`endif

    // Conversion sequencer: load, then WIDTH rounds of add-3 / shift
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= IDLE;
            scratch    <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
            o_Busy     <= 1'b0;
            o_Done     <= 1'b0;
            o_BCD      <= '0;
            o_Overflow <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_Start) begin
                        scratch    <= {{BW{1'b0}}, i_Binary};
                        count      <= '0;
                        ovf_sticky <= 1'b0;
                        o_Busy     <= 1'b1;
                        state      <= ADD3;
                    end
                end
                ADD3: begin
                    scratch <= scratch_add3;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    scratch    <= {scratch[SW-2:0], 1'b0};
                    ovf_sticky <= ovf_sticky | scratch[SW-1];
                    count      <= count_next;
                    if (count_next == CW'(WIDTH)) begin
                        state <= DONE;
                    end else begin
                        state <= ADD3;
                    end
                end
                DONE: begin
                    o_BCD      <= scratch[SW-1:WIDTH];
                    o_Overflow <= ovf_sticky;
                    o_Done     <= 1'b1;
                    o_Busy     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Directed bench for binary_to_bcd_converter.
// Covers 3-digit and 2-digit builds with or without BCD_BLANK_EN.
module tb_binary_to_bcd_converter;

    logic        i_Clk = 1'b0;
    logic        i_Rst_L = 1'b0;
    logic        i_Start = 1'b0;
    logic [7:0]  i_Binary = '0;
    logic        o_Busy;
    logic        o_Done;
    logic [11:0] o_BCD;
    logic        o_Overflow;
    logic [2:0]  o_Blank_Mask;

    logic        d2_start = 1'b0;
    logic [7:0]  d2_bin = '0;
    logic        d2_busy;
    logic        d2_done;
    logic [7:0]  d2_bcd;
    logic        d2_ovf;
    logic [1:0]  d2_mask;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_Clk = ~i_Clk;

    binary_to_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Start      (i_Start),
        .i_Binary     (i_Binary),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done),
        .o_BCD        (o_BCD),
        .o_Overflow   (o_Overflow),
        .o_Blank_Mask (o_Blank_Mask)
    );

    binary_to_bcd_converter #(.WIDTH(8), .DIGITS(2)) dut2 (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Start      (d2_start),
        .i_Binary     (d2_bin),
        .o_Busy       (d2_busy),
        .o_Done       (d2_done),
        .o_BCD        (d2_bcd),
        .o_Overflow   (d2_ovf),
        .o_Blank_Mask (d2_mask)
    );

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic [2:0]  mask;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] sel_mask(input logic [2:0] m);
`ifdef BCD_BLANK_EN
        return m;
`else
        return 3'b000;
`endif
    endfunction

    function automatic logic [11:0] model_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    function automatic logic [2:0] model_mask(input logic [11:0] b);
        logic [2:0] m;
        m    = 3'b000;
        m[2] = (b[11:8] == 4'd0);
        m[1] = m[2] && (b[7:4] == 4'd0);
        return sel_mask(m);
    endfunction

    // Start a conversion now; return edges from accept to o_Done
    task automatic do_conv(input logic [7:0] v, output int lat);
        i_Start  = 1'b1;
        i_Binary = v;
        @(posedge i_Clk);
        #1;
        i_Start  = 1'b0;
        i_Binary = 8'($urandom);
        lat = 0;
        while (!o_Done && lat < 40) begin
            @(posedge i_Clk);
            #1;
            lat++;
        end
    endtask

    task automatic d2_conv(input logic [7:0] v, output int lat);
        d2_start = 1'b1;
        d2_bin   = v;
        @(posedge i_Clk);
        #1;
        d2_start = 1'b0;
        d2_bin   = 8'($urandom);
        lat = 0;
        while (!d2_done && lat < 40) begin
            @(posedge i_Clk);
            #1;
            lat++;
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_busy"}, 32'(o_Busy), 0);
        chk({nm, "_done"}, 32'(o_Done), 0);
        chk({nm, "_bcd"},  32'(o_BCD), 0);
        chk({nm, "_ovf"},  32'(o_Overflow), 0);
        chk({nm, "_mask"}, 32'(o_Blank_Mask), 32'(sel_mask(3'b110)));
    endtask

    initial begin
        int lat;
        int got;
        bit busy_ok;

        tbl[0] = '{8'd0,   12'h000, 3'b110};
        tbl[1] = '{8'd5,   12'h005, 3'b110};
        tbl[2] = '{8'd9,   12'h009, 3'b110};
        tbl[3] = '{8'd10,  12'h010, 3'b100};
        tbl[4] = '{8'd37,  12'h037, 3'b100};
        tbl[5] = '{8'd99,  12'h099, 3'b100};
        tbl[6] = '{8'd100, 12'h100, 3'b000};
        tbl[7] = '{8'd123, 12'h123, 3'b000};
        tbl[8] = '{8'd200, 12'h200, 3'b000};
        tbl[9] = '{8'd255, 12'h255, 3'b000};

        repeat (2) @(posedge i_Clk);
        #1;
        chk_reset_vals("reset");
        i_Rst_L = 1'b1;
        @(posedge i_Clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            do_conv(tbl[i].bin, lat);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 17);
            chk($sformatf("tbl%0d_bcd", i), 32'(o_BCD), 32'(tbl[i].bcd));
            chk($sformatf("tbl%0d_ovf", i), 32'(o_Overflow), 0);
            chk($sformatf("tbl%0d_mask", i), 32'(o_Blank_Mask),
                32'(sel_mask(tbl[i].mask)));
            chk($sformatf("tbl%0d_busy", i), 32'(o_Busy), 0);
        end

        for (int v = 0; v < 256; v++) begin
            do_conv(8'(v), lat);
            chk($sformatf("sweep%0d_lat", v), 32'(lat), 17);
            chk($sformatf("sweep%0d_bcd", v), 32'(o_BCD),
                32'(model_bcd(v)));
            chk($sformatf("sweep%0d_mask", v), 32'(o_Blank_Mask),
                32'(model_mask(model_bcd(v))));
        end

        repeat (3) @(posedge i_Clk);
        #1;
        i_Start  = 1'b1;
        i_Binary = 8'd37;
        @(posedge i_Clk);
        #1;
        got = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3 || c == 17) begin
                i_Start  = 1'b1;
                i_Binary = 8'd200;
            end else begin
                i_Start  = 1'b0;
            end
            @(posedge i_Clk);
            #1;
            if (o_Done) begin
                got++;
                if (got == 1) begin
                    chk("ign_lat", 32'(c), 17);
                    chk("ign_bcd", 32'(o_BCD), 32'h037);
                end
            end else if (c < 17 && !o_Busy) begin
                busy_ok = 1'b0;
            end
        end
        i_Start = 1'b0;
        chk("ign_done_cnt", 32'(got), 1);
        chk("ign_busy_held", 32'(busy_ok), 1);
        chk("ign_idle", 32'(o_Busy), 0);

        i_Start  = 1'b1;
        i_Binary = 8'd123;
        @(posedge i_Clk);
        #1;
        i_Start = 1'b0;
        repeat (7) @(posedge i_Clk);
        #1;
        chk("rst_busy_before", 32'(o_Busy), 1);
        i_Rst_L = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        repeat (2) @(posedge i_Clk);
        #1;
        i_Rst_L = 1'b1;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge i_Clk);
            #1;
            if (o_Done) got++;
        end
        chk("rst_no_done", 32'(got), 0);
        chk("rst_bcd_hold", 32'(o_BCD), 0);
        do_conv(8'd45, lat);
        chk("post_rst_lat", 32'(lat), 17);
        chk("post_rst_bcd", 32'(o_BCD), 32'h045);

        d2_conv(8'd99, lat);
        chk("d2_99_lat", 32'(lat), 17);
        chk("d2_99_bcd", 32'(d2_bcd), 32'h99);
        chk("d2_99_ovf", 32'(d2_ovf), 0);
        d2_conv(8'd150, lat);
        chk("d2_150_lat", 32'(lat), 17);
        chk("d2_150_bcd", 32'(d2_bcd), 32'h50);
        chk("d2_150_ovf", 32'(d2_ovf), 1);
        d2_conv(8'd255, lat);
        chk("d2_255_bcd", 32'(d2_bcd), 32'h55);
        chk("d2_255_ovf", 32'(d2_ovf), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
